// File: rtl/poly_eval_gf32_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_gf32_if
// Brief    : Evaluate handshake, coefficient RAM port and GF32 multiplier port
//            bundle for poly_eval_gf32.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_eval_gf32_if #(
    parameter int T      = 3,
    parameter int ADDR_W = 8
);
    logic              i_start;
    logic [32*T-1:0]   i_r_eps;
    logic [ADDR_W-1:0] o_q_s_addr;
    logic              o_q_s_rd;
    logic [7:0]        i_q_s;
    logic              o_start_mul32;
    logic [31:0]       o_x_mul32;
    logic [31:0]       o_y_mul32;
    logic [31:0]       i_o_mul32;
    logic              i_done_mul32;
    logic [32*T-1:0]   o_evaluate_out;
    logic              o_done;

    modport master (
        output i_start, i_r_eps, i_q_s, i_o_mul32, i_done_mul32,
        input  o_q_s_addr, o_q_s_rd, o_start_mul32, o_x_mul32, o_y_mul32,
               o_evaluate_out, o_done
    );

    modport slave (
        input  i_start, i_r_eps, i_q_s, i_o_mul32, i_done_mul32,
        output o_q_s_addr, o_q_s_rd, o_start_mul32, o_x_mul32, o_y_mul32,
               o_evaluate_out, o_done
    );
endinterface
`default_nettype wire

// File: rtl/poly_eval_gf32.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_gf32
// Brief    : Horner evaluation of a GF256-coefficient polynomial at T points
//            in GF(2^32) using a shared external multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module poly_eval_gf32 #(
    parameter string PARAMETER_SET = "L1",
    parameter int    M        = (PARAMETER_SET == "L1") ? 230 :
                                (PARAMETER_SET == "L3") ? 352 : 480,
    parameter int    POLY_LEN = M,
    parameter int    T        = (PARAMETER_SET == "L5") ? 4 : 3
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    poly_eval_gf32_if.slave bus
);

    localparam int ADDR_W = $clog2(M);
    localparam int LANE_W = (T > 1) ? $clog2(T) : 1;

    localparam logic [2:0] C_IDLE     = 3'd0;
    localparam logic [2:0] C_FETCH    = 3'd1;
    localparam logic [2:0] C_CAPTURE  = 3'd2;
    localparam logic [2:0] C_MUL_REQ  = 3'd3;
    localparam logic [2:0] C_MUL_WAIT = 3'd4;
    localparam logic [2:0] C_NEXT     = 3'd5;
    localparam logic [2:0] C_DONE     = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [31:0]       r_pts [T];
    logic [31:0]       r_acc [T];
    logic [7:0]        r_coef;
    logic [ADDR_W-1:0] r_addr;
    logic              r_first;
    logic [LANE_W-1:0] r_lane;
    logic [LANE_W-1:0] w_lane_nxt;
    logic              w_last_lane;
    logic [31:0]       r_x;
    logic [31:0]       r_y;
    logic [32*T-1:0]   r_eval;
    logic              w_q_s_rd;
    logic              w_start_mul;
    logic              w_done;

    assign w_lane_nxt  = r_lane + LANE_W'(1);
    assign w_last_lane = (r_lane == LANE_W'(T - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE:     if (bus.i_start) w_next_state = C_FETCH;
            C_FETCH:    w_next_state = C_CAPTURE;
            C_CAPTURE:  w_next_state = r_first ? C_NEXT : C_MUL_REQ;
            C_MUL_REQ:  w_next_state = C_MUL_WAIT;
            C_MUL_WAIT: begin
                if (bus.i_done_mul32) begin
                    w_next_state = w_last_lane ? C_NEXT : C_MUL_REQ;
                end
            end
            C_NEXT:     w_next_state = (r_addr == '0) ? C_DONE : C_FETCH;
            C_DONE:     w_next_state = C_IDLE;
            default:    w_next_state = C_IDLE;
        endcase
    end

    always_comb begin
        w_q_s_rd    = 1'b0;
        w_start_mul = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            C_FETCH:   w_q_s_rd    = 1'b1;
            C_MUL_REQ: w_start_mul = 1'b1;
            C_DONE:    w_done      = 1'b1;
            default:   ;
        endcase
    end

    // Operands are loaded on entry to MUL_REQ so they are already stable
    // in the cycle the multiplier sees its start pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < T; j++) begin
                r_pts[j] <= '0;
                r_acc[j] <= '0;
            end
            r_coef  <= '0;
            r_addr  <= '0;
            r_first <= 1'b0;
            r_lane  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_eval  <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (bus.i_start) begin
                        for (int j = 0; j < T; j++) begin
                            r_pts[j] <= bus.i_r_eps[32*j +: 32];
                        end
                        r_addr  <= ADDR_W'(POLY_LEN - 1);
                        r_first <= 1'b1;
                    end
                end
                C_CAPTURE: begin
                    r_coef <= bus.i_q_s;
                    if (r_first) begin
                        for (int j = 0; j < T; j++) begin
                            r_acc[j] <= {24'b0, bus.i_q_s};
                        end
                        r_first <= 1'b0;
                    end else begin
                        r_lane <= '0;
                        r_x    <= r_acc[0];
                        r_y    <= r_pts[0];
                    end
                end
                C_MUL_WAIT: begin
                    if (bus.i_done_mul32) begin
                        r_acc[r_lane] <= bus.i_o_mul32 ^ {24'b0, r_coef};
                        if (!w_last_lane) begin
                            r_lane <= w_lane_nxt;
                            r_x    <= r_acc[w_lane_nxt];
                            r_y    <= r_pts[w_lane_nxt];
                        end
                    end
                end
                C_NEXT: begin
                    // Results are published as DONE is entered so they are
                    // valid alongside the done pulse.
                    if (r_addr == '0) begin
                        for (int j = 0; j < T; j++) begin
                            r_eval[32*j +: 32] <= r_acc[j];
                        end
                    end else begin
                        r_addr <= r_addr - ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_q_s_addr     = r_addr;
    assign bus.o_q_s_rd       = w_q_s_rd;
    assign bus.o_start_mul32  = w_start_mul;
    assign bus.o_x_mul32      = r_x;
    assign bus.o_y_mul32      = r_y;
    assign bus.o_evaluate_out = r_eval;
    assign bus.o_done         = w_done;

endmodule
`default_nettype wire
